// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its stream checker.
//   FIB_WIDTH   : default term width, common to generator and checker
//   FIB_SEED0/1 : the two seed terms every correct series starts with
//   fib_state_t : checker FSM states, exposed on the checker's state port
package fib_pkg;

    localparam int FIB_WIDTH = 32;
    localparam int FIB_SEED0 = 0;
    localparam int FIB_SEED1 = 1;

    typedef enum logic [2:0] {
        S_SEED0 = 3'd0,
        S_SEED1 = 3'd1,
        S_RUN   = 3'd2,
        S_FAIL  = 3'd3,
        S_SAT   = 3'd4
    } fib_state_t;

endpackage

// File: rtl/fib_stream_checker.sv
// Fibonacci term stream checker.
// Samples the term stream, checks the seeds (optionally) and that every later
// term is the sum of the previous two, counts good terms, latches the first
// mismatch and flags when the next term no longer fits in WIDTH bits.
//
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   clear        : synchronous restart, same effect as rst (rst has priority)
//   in_valid     : in_term is presented this cycle
//   in_term      : Fibonacci term from the generator
//   match        : one-cycle registered pulse per accepted correct term
//   term_count   : number of accepted correct terms, saturating at all-ones
//   err          : sticky mismatch flag
//   err_index    : 0-based index of the first bad term
//   err_expected : value the bad term should have had
//   err_actual   : bad term as received
//   sat          : sticky flag, the next term would exceed WIDTH bits
//   state        : current FSM state, for observation only
//
// Handshake: the input side is valid-only. A term is consumed on every rising
// edge where in_valid=1; there is no back-pressure, so the checker accepts or
// ignores (terminal states, clear) every presented term in that same cycle.
// Every output reflects the sample taken on the previous edge.
module fib_stream_checker
    import fib_pkg::*;
#(
    parameter int WIDTH      = FIB_WIDTH,
    parameter int CNT_W      = 8,
    parameter int SEED_CHECK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_term,
    output logic             match,
    output logic [CNT_W-1:0] term_count,
    output logic             err,
    output logic [CNT_W-1:0] err_index,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_actual,
    output logic             sat,
    output fib_state_t       state
);

    localparam bit CHECK_SEEDS = (SEED_CHECK != 0);

    fib_state_t       state_q, state_d;
    logic [WIDTH-1:0] prev1_q, prev1_d;
    logic [WIDTH-1:0] prev2_q, prev2_d;
    logic [WIDTH:0]   exp_sum;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] count_d, err_index_d;
    logic [WIDTH-1:0] err_expected_d, err_actual_d;
    logic             match_d, err_d, sat_d;

    assign state = state_q;

    // One extra bit so a carry out means the next term is unrepresentable.
    assign exp_sum   = {1'b0, prev1_q} + {1'b0, prev2_q};
    assign count_inc = (term_count == {CNT_W{1'b1}}) ? term_count
                                                     : term_count + CNT_W'(1);

    always_comb begin
        state_d        = state_q;
        prev1_d        = prev1_q;
        prev2_d        = prev2_q;
        count_d        = term_count;
        match_d        = 1'b0;
        err_d          = err;
        err_index_d    = err_index;
        err_expected_d = err_expected;
        err_actual_d   = err_actual;
        sat_d          = sat;

        case (state_q)
            S_SEED0: begin
                if (in_valid) begin
                    if (CHECK_SEEDS && (in_term != WIDTH'(FIB_SEED0))) begin
                        state_d        = S_FAIL;
                        err_d          = 1'b1;
                        err_index_d    = term_count;
                        err_expected_d = WIDTH'(FIB_SEED0);
                        err_actual_d   = in_term;
                    end else begin
                        prev1_d = in_term;
                        count_d = count_inc;
                        match_d = 1'b1;
                        state_d = S_SEED1;
                    end
                end
            end

            S_SEED1: begin
                if (in_valid) begin
                    if (CHECK_SEEDS && (in_term != WIDTH'(FIB_SEED1))) begin
                        state_d        = S_FAIL;
                        err_d          = 1'b1;
                        err_index_d    = term_count;
                        err_expected_d = WIDTH'(FIB_SEED1);
                        err_actual_d   = in_term;
                    end else begin
                        prev2_d = prev1_q;
                        prev1_d = in_term;
                        count_d = count_inc;
                        match_d = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                // The carry check does not wait for in_valid: sat rises the
                // cycle after the last representable term, and a term arriving
                // on that same edge is dropped rather than compared.
                if (exp_sum[WIDTH]) begin
                    state_d = S_SAT;
                    sat_d   = 1'b1;
                end else if (in_valid) begin
                    if (in_term == exp_sum[WIDTH-1:0]) begin
                        prev2_d = prev1_q;
                        prev1_d = in_term;
                        count_d = count_inc;
                        match_d = 1'b1;
                    end else begin
                        state_d        = S_FAIL;
                        err_d          = 1'b1;
                        err_index_d    = term_count;
                        err_expected_d = exp_sum[WIDTH-1:0];
                        err_actual_d   = in_term;
                    end
                end
            end

            // Terminal states: hold everything until rst or clear.
            S_FAIL, S_SAT: begin
            end

            default: begin
                state_d = S_SEED0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q      <= S_SEED0;
            prev1_q      <= '0;
            prev2_q      <= '0;
            match        <= 1'b0;
            term_count   <= '0;
            err          <= 1'b0;
            err_index    <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            sat          <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev1_q      <= prev1_d;
            prev2_q      <= prev2_d;
            match        <= match_d;
            term_count   <= count_d;
            err          <= err_d;
            err_index    <= err_index_d;
            err_expected <= err_expected_d;
            err_actual   <= err_actual_d;
            sat          <= sat_d;
        end
    end

endmodule

// File: tb/tb_fib_stream_checker.sv
// Bench for fib_stream_checker: an 8-bit instance for the directed streams and
// a 32-bit instance fed by a wrapping Fibonacci source for the full-length run.
module tb_fib_stream_checker;
    import fib_pkg::*;

    localparam logic [1:0] K_MATCH = 2'd0;
    localparam logic [1:0] K_ERR   = 2'd1;
    localparam logic [1:0] K_SAT   = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  cnt;   // term_count for match/sat, err_index for err
        logic [31:0] expv;
        logic [31:0] actv;
    } ev_t;

    ev_t exp_q8[$];
    ev_t exp_q32[$];

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8-bit DUT ----------------
    logic       rst8, clear8, v8;
    logic [7:0] t8;
    logic       match8, err8, sat8;
    logic [7:0] count8, idx8, eexp8, eact8;
    fib_state_t state8;

    fib_stream_checker #(.WIDTH(8), .CNT_W(8), .SEED_CHECK(1)) dut8 (
        .clk          (clk),
        .rst          (rst8),
        .clear        (clear8),
        .in_valid     (v8),
        .in_term      (t8),
        .match        (match8),
        .term_count   (count8),
        .err          (err8),
        .err_index    (idx8),
        .err_expected (eexp8),
        .err_actual   (eact8),
        .sat          (sat8),
        .state        (state8)
    );

    // ---------------- 32-bit DUT ----------------
    logic        rst32, clear32, v32;
    logic [31:0] t32;
    logic        match32, err32, sat32;
    logic [7:0]  count32, idx32;
    logic [31:0] eexp32, eact32;
    fib_state_t  state32;

    fib_stream_checker #(.WIDTH(32), .CNT_W(8), .SEED_CHECK(1)) dut32 (
        .clk          (clk),
        .rst          (rst32),
        .clear        (clear32),
        .in_valid     (v32),
        .in_term      (t32),
        .match        (match32),
        .term_count   (count32),
        .err          (err32),
        .err_index    (idx32),
        .err_expected (eexp32),
        .err_actual   (eact32),
        .sat          (sat32),
        .state        (state32)
    );

    logic [7:0] fib8 [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                              8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

    // ---------------- common check ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send8(input logic [7:0] t);
        v8 = 1'b1;
        t8 = t;
        @(posedge clk); #1;
        v8 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] t);
        v32 = 1'b1;
        t32 = t;
        @(posedge clk); #1;
        v32 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push8(input logic [1:0] k, input logic [7:0] c,
                         input logic [31:0] e, input logic [31:0] a);
        ev_t ev;
        ev.kind = k; ev.cnt = c; ev.expv = e; ev.actv = a;
        exp_q8.push_back(ev);
    endtask

    task automatic push32(input logic [1:0] k, input logic [7:0] c,
                          input logic [31:0] e, input logic [31:0] a);
        ev_t ev;
        ev.kind = k; ev.cnt = c; ev.expv = e; ev.actv = a;
        exp_q32.push_back(ev);
    endtask

    task automatic reset8(input string name);
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        check(name, {match8, count8, err8, idx8, eexp8, eact8, sat8}, 64'd0);
    endtask

    task automatic reset32(input string name);
        rst32 = 1'b1;
        @(posedge clk); #1;
        rst32 = 1'b0;
        check({name, "_ctl"}, {match32, count32, err32, idx32, sat32}, 64'd0);
        check({name, "_dat"}, {eexp32, eact32}, 64'd0);
    endtask

    // ---------------- monitors / scoreboard ----------------
    logic v8_s = 1'b0, v32_s = 1'b0;
    logic err8_d = 1'b0, sat8_d = 1'b0, err32_d = 1'b0, sat32_d = 1'b0;

    always @(posedge clk) begin
        v8_s  <= v8 && !rst8 && !clear8;
        v32_s <= v32 && !rst32 && !clear32;
    end

    always @(negedge clk) begin
        ev_t e;
        if (match8 || err8 || sat8)
            check("m8_exclusive", {match8 & err8, sat8 & err8}, 64'd0);
        if (match8) begin
            check("m8_match_aligned", v8_s, 1);
            if (exp_q8.size() == 0) check("m8_unexpected_match", 1, 0);
            else begin
                e = exp_q8.pop_front();
                check("m8_match_kind", e.kind, K_MATCH);
                check("m8_match_count", count8, e.cnt);
            end
        end
        if (err8 && !err8_d) begin
            if (exp_q8.size() == 0) check("m8_unexpected_err", 1, 0);
            else begin
                e = exp_q8.pop_front();
                check("m8_err_kind", e.kind, K_ERR);
                check("m8_err_index", idx8, e.cnt);
                check("m8_err_expected", eexp8, e.expv);
                check("m8_err_actual", eact8, e.actv);
            end
        end
        if (sat8 && !sat8_d) begin
            if (exp_q8.size() == 0) check("m8_unexpected_sat", 1, 0);
            else begin
                e = exp_q8.pop_front();
                check("m8_sat_kind", e.kind, K_SAT);
                check("m8_sat_count", count8, e.cnt);
            end
        end
        err8_d = err8;
        sat8_d = sat8;
    end

    always @(negedge clk) begin
        ev_t e;
        if (match32 || err32 || sat32)
            check("m32_exclusive", {match32 & err32, sat32 & err32}, 64'd0);
        if (match32) begin
            check("m32_match_aligned", v32_s, 1);
            if (exp_q32.size() == 0) check("m32_unexpected_match", 1, 0);
            else begin
                e = exp_q32.pop_front();
                check("m32_match_kind", e.kind, K_MATCH);
                check("m32_match_count", count32, e.cnt);
            end
        end
        if (err32 && !err32_d) begin
            if (exp_q32.size() == 0) check("m32_unexpected_err", 1, 0);
            else begin
                e = exp_q32.pop_front();
                check("m32_err_kind", e.kind, K_ERR);
                check("m32_err_index", idx32, e.cnt);
                check("m32_err_expected", eexp32, e.expv);
                check("m32_err_actual", eact32, e.actv);
            end
        end
        if (sat32 && !sat32_d) begin
            if (exp_q32.size() == 0) check("m32_unexpected_sat", 1, 0);
            else begin
                e = exp_q32.pop_front();
                check("m32_sat_kind", e.kind, K_SAT);
                check("m32_sat_count", count32, e.cnt);
            end
        end
        err32_d = err32;
        sat32_d = sat32;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, b, nxt;

        rst8 = 1'b1; clear8 = 1'b0; v8 = 1'b0; t8 = '0;
        rst32 = 1'b1; clear32 = 1'b0; v32 = 1'b0; t32 = '0;
        idle(3);
        check("rst8_state", {match8, count8, err8, idx8, eexp8, eact8, sat8}, 64'd0);
        check("rst32_ctl", {match32, count32, err32, idx32, sat32}, 64'd0);
        check("rst32_dat", {eexp32, eact32}, 64'd0);
        rst8 = 1'b0;

        // 1: full 8-bit stream back-to-back
        for (int i = 0; i < 14; i++) begin
            push8(K_MATCH, 8'(i + 1), 0, 0);
            if (i == 13) push8(K_SAT, 8'd14, 0, 0);
            send8(fib8[i]);
        end
        idle(3);
        check("t1_count", count8, 14);
        check("t1_sat", sat8, 1);
        check("t1_err", err8, 0);
        check("t1_drained", exp_q8.size(), 0);
        reset8("t1_reset");

        // 2: mismatch at index 4, trailing term ignored
        for (int i = 0; i < 4; i++) begin
            push8(K_MATCH, 8'(i + 1), 0, 0);
            send8(fib8[i]);
        end
        push8(K_ERR, 8'd4, 32'd3, 32'd4);
        send8(8'd4);
        send8(8'd7);
        idle(2);
        check("t2_count", count8, 4);
        check("t2_err", err8, 1);
        check("t2_sat", sat8, 0);
        check("t2_drained", exp_q8.size(), 0);
        reset8("t2_reset");

        // 3: bad first seed
        push8(K_ERR, 8'd0, 32'd0, 32'd5);
        send8(8'd5);
        idle(2);
        check("t3_count", count8, 0);
        check("t3_err", err8, 1);
        check("t3_drained", exp_q8.size(), 0);
        reset8("t3_reset");

        // 4: same stream with random gaps
        for (int i = 0; i < 14; i++) begin
            push8(K_MATCH, 8'(i + 1), 0, 0);
            if (i == 13) push8(K_SAT, 8'd14, 0, 0);
            send8(fib8[i]);
            idle($urandom_range(0, 5));
        end
        idle(3);
        check("t4_count", count8, 14);
        check("t4_sat", sat8, 1);
        check("t4_err", err8, 0);
        check("t4_drained", exp_q8.size(), 0);
        reset8("t4_reset");

        // 5: clear with a simultaneous term, then a clean restart
        for (int i = 0; i < 5; i++) begin
            push8(K_MATCH, 8'(i + 1), 0, 0);
            send8(fib8[i]);
        end
        clear8 = 1'b1;
        send8(fib8[5]);
        clear8 = 1'b0;
        check("t5_clear", {match8, count8, err8, idx8, eexp8, eact8, sat8}, 64'd0);
        for (int i = 0; i < 7; i++) begin
            push8(K_MATCH, 8'(i + 1), 0, 0);
            send8(fib8[i]);
        end
        idle(2);
        check("t5_count", count8, 7);
        check("t5_err", err8, 0);
        check("t5_drained", exp_q8.size(), 0);

        // 6: 32-bit run from a wrapping source, then rst out of S_FAIL
        idle(2);
        rst32 = 1'b0;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < 53; i++) begin
            if (i < 48) push32(K_MATCH, 8'(i + 1), 0, 0);
            if (i == 47) push32(K_SAT, 8'd48, 0, 0);
            send32(a);
            nxt = a + b;
            a = b;
            b = nxt;
        end
        idle(2);
        check("t6_count", count32, 48);
        check("t6_sat", sat32, 1);
        check("t6_err", err32, 0);
        check("t6_drained", exp_q32.size(), 0);
        reset32("t6_reset");

        push32(K_MATCH, 8'd1, 0, 0);
        send32(32'd0);
        push32(K_MATCH, 8'd2, 0, 0);
        send32(32'd1);
        push32(K_ERR, 8'd2, 32'd1, 32'd3);
        send32(32'd3);
        idle(2);
        check("t6_fail_err", err32, 1);
        check("t6_fail_drained", exp_q32.size(), 0);
        reset32("t6_rst_in_fail");

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fib_stream_checker.md
Name: fib_stream_checker

Overview:
Downstream consumer of the Fibonacci series generator. It samples the 32-bit term stream and checks that the first two terms are 0 and 1 and that every later term equals the sum of the previous two. It counts good terms, latches details of the first mismatch, and flags when the next term can no longer be represented in WIDTH bits. It serves both as a self-checking monitor in the generator's bench and as a synthesizable on-chip health check.

Parameters:
WIDTH, 32, term width; must match the generator output width.
CNT_W, 8, width of the term counter and error index.
SEED_CHECK, 1, when 1 the first term must be 0 and the second must be 1; when 0 the first two terms are accepted as seeds unchecked.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
clear  input  1  synchronous restart; same effect as rst, lower priority than rst.
in_valid  input  1  in_term is presented this cycle.
in_term  input  WIDTH  Fibonacci term from the generator.
match  output  1  one-cycle pulse, registered, for each accepted correct term.
term_count  output  CNT_W  number of accepted correct terms; saturates at all-ones.
err  output  1  sticky mismatch flag.
err_index  output  CNT_W  0-based index of the first bad term.
err_expected  output  WIDTH  value the bad term should have had.
err_actual  output  WIDTH  bad term as received.
sat  output  1  sticky flag: the next term would exceed WIDTH bits.

Behaviour:
- Reset (rst=1 at an edge): state goes to S_SEED0. All outputs and the internal registers prev1 and prev2 go to 0. rst overrides every other input.
- clear=1 (with rst=0): identical effect to reset. If in_valid is also high that cycle, the term is dropped.
- All outputs are registered. Each response appears on the cycle after the in_valid sample that caused it.
- Idle cycles (in_valid=0) change nothing. Gaps of any length are legal.
- S_SEED0, on in_valid:
  - If SEED_CHECK=1 and in_term is not 0: go to S_FAIL (index 0, expected 0).
  - Otherwise: prev1 <= in_term, count increments, match pulses, go to S_SEED1.
- S_SEED1, on in_valid:
  - If SEED_CHECK=1 and in_term is not 1: go to S_FAIL (expected 1).
  - Otherwise: prev2 <= prev1, prev1 <= in_term, count increments, match pulses, go to S_RUN.
- S_RUN:
  - exp is prev1 + prev2, computed WIDTH+1 bits wide.
  - Saturation check runs every cycle, whether or not in_valid is high: if exp[WIDTH]=1, go to S_SAT and set sat=1.
  - In practice, sat rises on the cycle after the last representable term is accepted.
  - On in_valid with no carry and in_term == exp[WIDTH-1:0]: prev2 <= prev1, prev1 <= in_term, count increments, match pulses.
  - On in_valid with a mismatch: go to S_FAIL.
- Entering S_FAIL: err=1, err_index=term_count, err_expected=expected value, err_actual=in_term. match does not pulse and count does not change.
- S_FAIL and S_SAT are terminal. All input is ignored and outputs hold until rst or clear.
- A term arriving in S_SAT (for example, the generator wrapping) is not compared and is never flagged as an error.
- term_count saturates at 2^CNT_W-1 and does not wrap. The error index in that case equals the saturated count.
- match and err are never high in the same cycle. sat and err are mutually exclusive.
- Reference values:
  - WIDTH=32: the last representable term is F47=2971215073. A full run ends with term_count=48 and sat=1.
  - WIDTH=8: the last term is F13=233. A full run ends with term_count=14 and sat=1.

Decomposition:
- Shared package fib_pkg holds:
  - the state enum (S_SEED0, S_SEED1, S_RUN, S_FAIL, S_SAT);
  - the default FIB_WIDTH=32, shared with the generator;
  - constants FIB_SEED0=0 and FIB_SEED1=1.
- No sub-module. The adder and compare are inline, single-cycle. Expected implementation size is roughly 150 lines.

Test Plan:
1. WIDTH=8, back-to-back stream 0,1,1,2,...,233 -> 14 match pulses, term_count=14, sat=1 the cycle after 233 is sampled, err=0.
2. WIDTH=8, stream 0,1,1,2,4,7 -> err=1 the cycle after 4, err_index=4, err_expected=3, err_actual=4, term_count=4; the term 7 is ignored.
3. SEED_CHECK=1, first term 5 -> err_index=0, err_expected=0, err_actual=5, term_count=0.
4. Correct stream from scenario 1 with 0-5 random idle cycles between terms -> identical final state; match pulses line up with valid samples.
5. After 5 good terms, clear together with in_valid -> all outputs 0 next cycle and the term dropped; a fresh 0,1,1,... stream then checks clean.
6. WIDTH=32, generator connected directly, rst held then released -> term_count=48, sat=1 after 2971215073; later wrapped terms give err=0. rst asserted while in S_FAIL -> all outputs 0 on the next cycle.
